// File: rtl/cx_req_tracker_if.sv
// Handshake bundles around the CX request tracker: core-side and switch-side channels.
// Latency: none, these are plain wire bundles.
// Backpressure: valid/ready on both the request and response directions.
//
// cx_core_if : in-order issue port of the core (no ids visible to the core).
//   master = core, slave = tracker.
// cx_cxu_if  : slave-side request/response channels of the CX switch (carry ids).
//   master = tracker, slave = switch.

interface cx_core_if #(
    parameter int DATA_W   = 32,
    parameter int STATUS_W = 1,
    parameter int CXU_W    = 4,
    parameter int STATE_W  = 2,
    parameter int FUNC_W   = 10
);
    logic                req_valid;
    logic                req_ready;
    logic [CXU_W-1:0]    req_cxu;
    logic [STATE_W-1:0]  req_state;
    logic [FUNC_W-1:0]   req_func;
    logic [DATA_W-1:0]   req_data0;
    logic [DATA_W-1:0]   req_data1;
    logic [31:0]         req_insn;
    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_W-1:0]   resp_data;
    logic [STATUS_W-1:0] resp_status;

    modport master (
        output req_valid, req_cxu, req_state, req_func, req_data0, req_data1, req_insn,
        input  req_ready,
        input  resp_valid, resp_data, resp_status,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_cxu, req_state, req_func, req_data0, req_data1, req_insn,
        output req_ready,
        output resp_valid, resp_data, resp_status,
        input  resp_ready
    );
endinterface

interface cx_cxu_if #(
    parameter int ID_W     = 4,
    parameter int DATA_W   = 32,
    parameter int STATUS_W = 1,
    parameter int CXU_W    = 4,
    parameter int STATE_W  = 2,
    parameter int FUNC_W   = 10
);
    logic                req_valid;
    logic                req_ready;
    logic [CXU_W-1:0]    req_cxu;
    logic [STATE_W-1:0]  req_state;
    logic [FUNC_W-1:0]   req_func;
    logic [DATA_W-1:0]   req_data0;
    logic [DATA_W-1:0]   req_data1;
    logic [31:0]         req_insn;
    logic [ID_W-1:0]     req_id;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [DATA_W-1:0]   resp_data;
    logic [STATUS_W-1:0] resp_status;

    modport master (
        output req_valid, req_cxu, req_state, req_func, req_data0, req_data1, req_insn, req_id,
        input  req_ready,
        input  resp_valid, resp_id, resp_data, resp_status,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_cxu, req_state, req_func, req_data0, req_data1, req_insn, req_id,
        output req_ready,
        output resp_valid, resp_id, resp_data, resp_status,
        input  resp_ready
    );
endinterface

// File: rtl/cx_req_tracker.sv
// Tags in-order CX requests with ids, reorders out-of-order switch responses, retires in issue order.
// Latency: request path 0 cycles (combinational); response to core >= 1 cycle after switch response.
// Backpressure: issue stalls when DEPTH requests are outstanding; switch responses are never stalled.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   s              core side (cx_core_if.slave): in-order requests in, in-order responses out
//   m              switch side (cx_cxu_if.master): id-tagged requests out, responses in any order
//   o_outstanding  issued-but-not-retired count
//   o_spurious     sticky flag: a response with a non-outstanding id was dropped

module cx_req_tracker #(
    parameter int DEPTH    = 4,
    parameter int ID_W     = 4,
    parameter int DATA_W   = 32,
    parameter int STATUS_W = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    cx_core_if.slave               s,
    cx_cxu_if.master               m,
    output logic [$clog2(DEPTH):0] o_outstanding,
    output logic                   o_spurious
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PTR_W-1:0]    issue_ptr_q, issue_ptr_d;
    logic [PTR_W-1:0]    retire_ptr_q, retire_ptr_d;
    logic [DEPTH-1:0]    pending_q, pending_d;
    logic [DEPTH-1:0]    done_q, done_d;
    logic                spurious_q, spurious_d;
    logic                m_resp_ready_q, m_resp_ready_d;
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic [STATUS_W-1:0] status_q [DEPTH];
    logic [STATUS_W-1:0] status_d [DEPTH];

    logic [PTR_W-1:0] count;
    logic             full;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] retire_idx;
    logic [IDX_W-1:0] resp_idx;
    logic             resp_hi_ok;
    logic             issue_fire;
    logic             resp_fire;
    logic             resp_match;
    logic             retire_fire;

    always_comb begin
        count      = issue_ptr_q - retire_ptr_q;
        full       = (count == DEPTH_P);
        issue_idx  = issue_ptr_q[IDX_W-1:0];
        retire_idx = retire_ptr_q[IDX_W-1:0];
        resp_idx   = m.resp_id[IDX_W-1:0];
        // Ids beyond the slot range can never have been issued.
        resp_hi_ok = ((m.resp_id >> IDX_W) == '0);
    end

    // Request path: straight passthrough, gated only by the registered occupancy.
    // A retire in the same cycle does not free a slot for issue until the next cycle.
    assign m.req_valid = s.req_valid & ~full & ~i_rst;
    assign s.req_ready = m.req_ready & ~full & ~i_rst;
    assign m.req_cxu   = s.req_cxu;
    assign m.req_state = s.req_state;
    assign m.req_func  = s.req_func;
    assign m.req_data0 = s.req_data0;
    assign m.req_data1 = s.req_data1;
    assign m.req_insn  = s.req_insn;
    assign m.req_id    = ID_W'(issue_idx);

    assign m.resp_ready = m_resp_ready_q;

    // Retire side: head of the reorder buffer, presented once its result has landed.
    assign s.resp_valid  = done_q[retire_idx];
    assign s.resp_data   = data_q[retire_idx];
    assign s.resp_status = status_q[retire_idx];

    assign issue_fire  = m.req_valid & m.req_ready;
    assign resp_fire   = m.resp_valid & m_resp_ready_q;
    // A slot already done (including one being retired now) rejects a second response.
    assign resp_match  = resp_fire & pending_q[resp_idx] & ~done_q[resp_idx] & resp_hi_ok;
    assign retire_fire = s.resp_valid & s.resp_ready;

    assign o_outstanding = count;
    assign o_spurious    = spurious_q;

    always_comb begin
        issue_ptr_d    = issue_ptr_q + PTR_W'(issue_fire);
        retire_ptr_d   = retire_ptr_q + PTR_W'(retire_fire);
        pending_d      = pending_q;
        done_d         = done_q;
        spurious_d     = spurious_q | (resp_fire & ~resp_match);
        m_resp_ready_d = 1'b1;
        data_d         = data_q;
        status_d       = status_q;

        // Issue, response and retire always address distinct slots when they coincide.
        if (retire_fire) begin
            pending_d[retire_idx] = 1'b0;
            done_d[retire_idx]    = 1'b0;
        end
        if (issue_fire) begin
            pending_d[issue_idx] = 1'b1;
            done_d[issue_idx]    = 1'b0;
        end
        if (resp_match) begin
            done_d[resp_idx]   = 1'b1;
            data_d[resp_idx]   = m.resp_data;
            status_d[resp_idx] = m.resp_status;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            issue_ptr_q    <= '0;
            retire_ptr_q   <= '0;
            pending_q      <= '0;
            done_q         <= '0;
            spurious_q     <= 1'b0;
            m_resp_ready_q <= 1'b0;
        end else begin
            issue_ptr_q    <= issue_ptr_d;
            retire_ptr_q   <= retire_ptr_d;
            pending_q      <= pending_d;
            done_q         <= done_d;
            spurious_q     <= spurious_d;
            m_resp_ready_q <= m_resp_ready_d;
        end
    end

    // Result storage is qualified by done bits, so it needs no reset.
    always_ff @(posedge i_clk) begin
        data_q   <= data_d;
        status_q <= status_d;
    end

endmodule

// File: doc/cx_req_tracker.md
Name: cx_req_tracker

Overview:
- Sits directly upstream of the CX switch unit, between the core's in-order CX issue port and the switch's slave-side cxu request/response channels.
- Assigns each request a req_id and caps outstanding requests at DEPTH.
- Collects responses, which return out of order across CXUs, into a reorder buffer indexed by req_id, then returns them to the core strictly in issue order.
- Detects and drops responses carrying an id that is not outstanding.

Parameters:
DEPTH, 4, max outstanding requests; power of 2, >=2, <= 2**ID_W
ID_W, 4, req_id/resp_id width (C_M_CXU_REQ_ID_W)
DATA_W, 32, operand/result width (C_M_CXU_DATA_W)
STATUS_W, 1, response status width (C_M_CXU_STATUS_W)
CXU_W, 4, CXU selector width
STATE_W, 2, state-context selector width
FUNC_W, 10, function field width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
s_req_valid  in  1  core request valid
s_req_ready  out  1  core request accepted
s_req_cxu/s_req_state/s_req_func  in  CXU_W/STATE_W/FUNC_W  request fields
s_req_data0/s_req_data1  in  DATA_W  operands
s_req_insn  in  32  raw instruction
s_resp_valid  out  1  in-order response valid to core
s_resp_ready  in  1  core accepts response
s_resp_data  out  DATA_W  result
s_resp_status  out  STATUS_W  status (nonzero = error, passed through unchanged)
m_req_valid  out  1  request to switch
m_req_ready  in  1  switch accepts request
m_req_cxu/state/func/data0/data1/insn  out  as s_req_*  forwarded fields
m_req_id  out  ID_W  assigned id
m_resp_valid  in  1  switch response valid
m_resp_ready  out  1  always 1 after reset
m_resp_id  in  ID_W  response id
m_resp_data  in  DATA_W  response data
m_resp_status  in  STATUS_W  response status
o_outstanding  out  clog2(DEPTH)+1  issued-not-retired count
o_spurious  out  1  sticky: an unmatched response was dropped

Behaviour:
- State: issue_ptr and retire_ptr, each clog2(DEPTH)+1 bits, wrapping naturally. count = issue_ptr - retire_ptr. full = (count == DEPTH).
- Per slot: pending bit, done bit, data and status registers.
- Reset (async, i_rst=1): pointers=0, all pending/done=0, o_spurious=0, m_resp_ready=0 during reset. All valids/readies low, o_outstanding=0. Data/status storage is not reset.
- Request path is combinational passthrough:
  - m_req_valid = s_req_valid & ~full.
  - s_req_ready = m_req_ready & ~full.
  - m_req_* = s_req_*.
  - m_req_id = zero-extended issue_ptr[clog2(DEPTH)-1:0].
- Issue fire (m_req_valid & m_req_ready): issue_ptr++, slot pending=1, done=0.
- full uses the registered count only. A retire in the same cycle does not unblock issue; no bypass.
- Response accept (m_resp_valid, m_resp_ready=1):
  - slot = m_resp_id[clog2(DEPTH)-1:0].
  - Match requires slot pending=1, done=0 and upper id bits zero.
  - On match: store data/status, done=1.
  - Otherwise: drop, set o_spurious=1, which holds until reset.
- Retire:
  - s_resp_valid = done[retire slot].
  - s_resp_data/status come from the retire slot's registers.
  - Fire (s_resp_valid & s_resp_ready): pending=0, done=0, retire_ptr++.
- Latency:
  - Request: 0 cycles, combinational.
  - Response: minimum 1 cycle from m_resp fire to s_resp_valid.
- A response arriving for the slot being retired in the same cycle is impossible, since that slot is already done and the response is flagged spurious.
- Same-cycle issue into a slot being retired: not possible, because full blocks it.
- Simultaneous issue + response + retire on distinct slots: all take effect. o_outstanding = count + issue - retire next cycle.
- Error status (e.g. switch invalid-CXU error) is retired in order like any result; status is not interpreted.
- Reset mid-operation: all in-flight state is discarded. Later responses from the switch for old ids are flagged spurious.

Test Plan:
- Single op: issue cxu=0, data0=5; switch returns id=0, data=0x2A, status=0 -> s_resp_valid one cycle later with 0x2A; o_outstanding goes 1 then 0.
- Out-of-order: issue ids 0,1,2; responses arrive in order 2,0,1 with data 0xC,0xA,0xB -> core sees 0xA,0xB,0xC in order. s_resp_valid stays low until id 0 lands.
- Full: with DEPTH=4 issue 4 with no responses -> s_req_ready=0 and m_req_valid=0 on the 5th. Retiring id0 re-enables issue on the next cycle only. 5th request gets m_req_id=0.
- Pointer wrap: 10 back-to-back issue/respond/retire cycles -> ids go 0,1,2,3,0,1,… and no spurious flag.
- Spurious: response id=3 with nothing outstanding, then a duplicate id for an already-done slot -> both dropped, o_spurious=1, and the retired data is unchanged.
- Async reset asserted with 3 outstanding and s_resp_ready=0 -> outputs clear immediately. After release: o_outstanding=0, o_spurious=0, next request gets id 0.
